run_control_unit: RTL and testbench
===================================

Name: run_control_unit

Overview:
Run/halt sequencer for the single-cycle processor. It generates the power-up PC reset pulse and a commit enable that gates PC load, RegWrite and MemWrite in the datapath. It supports run, halt, single-step and a PC breakpoint. It sits beside the controller at top level: pc_reset drives the datapath PCReset, and cpu_en is ANDed into the commit strobes.

Parameters:
PC_WIDTH, 8, width of pc and bp_addr.
RESET_CYCLES, 3, number of cycles pc_reset stays high after reset deasserts; must be >= 1.
CNT_WIDTH, 16, width of cycle_count.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run_req  input  1  request free-running execution (level sampled each edge)
halt_req  input  1  request halt
step_req  input  1  request execution of exactly one instruction
pc  input  PC_WIDTH  current PC from the datapath
bp_en  input  1  breakpoint enable
bp_addr  input  PC_WIDTH  breakpoint PC
pc_reset  output  1  drives datapath PCReset
cpu_en  output  1  commit enable for the current instruction (combinational from state/pc)
halted  output  1  high in HALT or BREAK
state  output  3  encoding: 0 RST_HOLD, 1 HALT, 2 RUN, 3 STEP, 4 BREAK
cycle_count  output  CNT_WIDTH  count of committed instructions

Behaviour:
- Reset (sampled at an edge): next state RST_HOLD, hold counter = 0, cycle_count = 0, bp_skip = 0. Reset overrides everything in any state, including mid-RUN and mid-STEP.
- Outputs in RST_HOLD: pc_reset = 1, cpu_en = 0, halted = 0.
- RST_HOLD: while reset is low, the hold counter increments each cycle. When the counter equals RESET_CYCLES-1 at an edge, go to HALT. pc_reset is therefore high for exactly RESET_CYCLES cycles after reset falls. All requests are ignored in this state.
- pc_reset = 0 in every state other than RST_HOLD.
- HALT: cpu_en = 0. Transitions:
  - halt_req: stay in HALT.
  - else step_req: go to STEP.
  - else run_req: go to RUN.
- Request priority everywhere: halt_req > step_req > run_req.
- RUN:
  - bp_hit = bp_en & (pc == bp_addr) & !bp_skip.
  - cpu_en = !bp_hit.
  - halt_req: go to HALT. The instruction in this cycle still commits unless bp_hit.
  - else bp_hit: go to BREAK. The instruction at bp_addr is not committed.
  - step_req and run_req are ignored in RUN.
- STEP: cpu_en = 1 for exactly one cycle, breakpoint ignored, then go to HALT unconditionally. Requests in this cycle are ignored.
- BREAK: cpu_en = 0, halted = 1.
  - halt_req: go to HALT.
  - else step_req: go to STEP.
  - else run_req: set bp_skip = 1, go to RUN.
- bp_skip: cleared on the first cycle with cpu_en = 1 after being set. This lets resume-from-breakpoint execute the bp_addr instruction once, without re-trapping.
- Leaving BREAK via STEP also sets bp_skip. It is cleared by the stepped commit.
- cycle_count: +1 on every edge where cpu_en = 1. Wraps from all-ones to 0 with no flag.
- Request inputs are levels. A request held high re-triggers on every edge it is eligible; pulses of 1 cycle are the intended use.
- No combinational path from run_req, halt_req or step_req to cpu_en. cpu_en depends only on state, pc, bp_en, bp_addr and bp_skip.

Optional Feature:
RUN_CONTROL_BREAKPOINT_EN
- Defined: breakpoint logic, bp_skip and the BREAK state behave as above.
- Undefined: bp_hit is tied to 0, BREAK is unreachable, and bp_en/bp_addr are ignored (ports retained). In RUN, cpu_en = 1 whenever not halting via the next edge. All other behaviour is identical.

Test Plan:
1. Power-up: reset high 2 cycles, then low. Expect pc_reset = 1 for exactly 3 cycles after the fall, then state = 1 (HALT), halted = 1, cpu_en = 0, cycle_count = 0.
2. Run then halt: from HALT, pulse run_req, run 10 cycles, then pulse halt_req. Expect cpu_en = 1 for 11 cycles including the halt_req cycle, cycle_count = 11, state = 1.
3. Single step: from HALT, pulse step_req. Expect state = 3 for 1 cycle with cpu_en = 1, then state = 1, cycle_count + 1. Holding step_req high 4 cycles yields alternating STEP/HALT and +2.
4. Breakpoint (macro defined): bp_en = 1, bp_addr = 8'h05, run with pc advancing 0,1,2... Expect cpu_en = 0 when pc = 5 and state = 4 next. Pulse run_req: the pc = 5 instruction commits (cpu_en = 1), execution continues, and a later pc = 5 traps again.
5. Simultaneous requests: in HALT assert run_req, step_req and halt_req together. Expect state stays 1. With step_req and run_req only, expect state = 3.
6. Reset mid-RUN: assert reset while state = 2 with cycle_count = 7. Next edge: state = 0, cycle_count = 0, pc_reset = 1, cpu_en = 0. With the macro undefined, repeat scenario 4 and expect no trap at pc = 5.

Source files
------------

// File: rtl/run_control_unit.sv
// Run/halt sequencer: PC reset pulse, commit enable, single-step and breakpoint.
// Ports: clk_i, reset_i (sync, active-high), run_req_i/halt_req_i/step_req_i
//    (level requests, halt > step > run), pc_i, bp_en_i, bp_addr_i;
//    outputs pc_reset_o, cpu_en_o (commit enable), halted_o, state_o
//    (0 RST_HOLD, 1 HALT, 2 RUN, 3 STEP, 4 BREAK), cycle_count_o (commits).
// Optional: define RUN_CONTROL_BREAKPOINT_EN for breakpoint/BREAK support.
module run_control_unit #(
   parameter int PC_WIDTH     = 8,
   parameter int RESET_CYCLES = 3,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 run_req_i,
   input  logic                 halt_req_i,
   input  logic                 step_req_i,
   input  logic [PC_WIDTH-1:0]  pc_i,
   input  logic                 bp_en_i,
   input  logic [PC_WIDTH-1:0]  bp_addr_i,
   output logic                 pc_reset_o,
   output logic                 cpu_en_o,
   output logic                 halted_o,
   output logic [2:0]           state_o,
   output logic [CNT_WIDTH-1:0] cycle_count_o
);

   localparam logic [2:0] RST_HOLD = 3'd0;
   localparam logic [2:0] HALT     = 3'd1;
   localparam logic [2:0] RUN      = 3'd2;
   localparam logic [2:0] STEP     = 3'd3;
   localparam logic [2:0] BRK      = 3'd4;

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

   logic [2:0]           state_q, state_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 bp_hit;
   logic                 cpu_en;

`ifdef RUN_CONTROL_BREAKPOINT_EN
   logic bp_skip_q, bp_skip_d;

   // bp_skip lets a resume execute the trapped instruction once
   assign bp_hit = bp_en_i && (pc_i == bp_addr_i) && !bp_skip_q;

   always_comb begin
      bp_skip_d = bp_skip_q;
      if (cpu_en)
         bp_skip_d = 1'b0;
      if (state_q == BRK && !halt_req_i && (step_req_i || run_req_i))
         bp_skip_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         bp_skip_q <= 1'b0;
      else
         bp_skip_q <= bp_skip_d;
   end
`else
   logic unused_bp;

   assign bp_hit    = 1'b0;
   assign unused_bp = ^{bp_en_i, bp_addr_i, pc_i};
`endif

   // Depends only on state and breakpoint match, never on requests
   always_comb begin
      cpu_en = 1'b0;
      case (state_q)
         RUN:     cpu_en = !bp_hit;
         STEP:    cpu_en = 1'b1;
         default: cpu_en = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         RST_HOLD: begin
            if (hold_q == HOLD_LAST)
               state_d = HALT;
            else
               hold_d = hold_q + 1'b1;
         end
         HALT, BRK: begin
            if (halt_req_i)
               state_d = HALT;
            else if (step_req_i)
               state_d = STEP;
            else if (run_req_i)
               state_d = RUN;
         end
         RUN: begin
            if (halt_req_i)
               state_d = HALT;
            else if (bp_hit)
               state_d = BRK;
         end
         STEP:    state_d = HALT;
         default: state_d = RST_HOLD;
      endcase
   end

   assign cnt_d = cpu_en ? cnt_q + CNT_WIDTH'(1) : cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= RST_HOLD;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_reset_o    = (state_q == RST_HOLD);
   assign cpu_en_o      = cpu_en;
   assign halted_o      = (state_q == HALT) || (state_q == BRK);
   assign state_o       = state_q;
   assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_run_control_unit.sv
// Scoreboard bench for run_control_unit: driver queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_run_control_unit;

   localparam logic [2:0] S_RST  = 3'd0;
   localparam logic [2:0] S_HALT = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_STEP = 3'd3;
   localparam logic [2:0] S_BRK  = 3'd4;

   typedef struct packed {
      logic        pr;
      logic        en;
      logic        hl;
      logic [2:0]  st;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_req = 1'b0;
   logic        halt_req = 1'b0;
   logic        step_req = 1'b0;
   logic [7:0]  pc = 8'd0;
   logic        bp_en = 1'b0;
   logic [7:0]  bp_addr = 8'h05;
   logic        pc_reset;
   logic        cpu_en;
   logic        halted;
   logic [2:0]  state;
   logic [15:0] cycle_count;

   exp_t        sb[$];
   logic [15:0] exp_cnt = 16'd0;
   int          checks = 0;
   int          failures = 0;
   int          ncyc = 0;

   run_control_unit #(
      .PC_WIDTH(8),
      .RESET_CYCLES(3),
      .CNT_WIDTH(16)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .run_req_i(run_req),
      .halt_req_i(halt_req),
      .step_req_i(step_req),
      .pc_i(pc),
      .bp_en_i(bp_en),
      .bp_addr_i(bp_addr),
      .pc_reset_o(pc_reset),
      .cpu_en_o(cpu_en),
      .halted_o(halted),
      .state_o(state),
      .cycle_count_o(cycle_count)
   );

   always #5 clk = ~clk;

   // One cycle: apply inputs for this cycle and queue what the outputs
   // must show during it. The count model follows the commit rule.
   task automatic cyc(input logic r, input logic rn, input logic hl,
                      input logic sp, input logic [7:0] p,
                      input logic [2:0] st, input logic en);
      exp_t e;
      @(posedge clk);
      #1;
      reset    = r;
      run_req  = rn;
      halt_req = hl;
      step_req = sp;
      pc       = p;
      e.pr  = (st == S_RST);
      e.en  = en;
      e.hl  = (st == S_HALT) || (st == S_BRK);
      e.st  = st;
      e.cnt = exp_cnt;
      sb.push_back(e);
      exp_cnt = r ? 16'd0 : exp_cnt + 16'(en);
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         g = {pc_reset, cpu_en, halted, state, cycle_count};
         checks++;
         ncyc++;
         if (g !== e) begin
            failures++;
            $display("FAIL cyc%0d got pr=%b en=%b hl=%b st=%0d cnt=%0d exp pr=%b en=%b hl=%b st=%0d cnt=%0d",
                     ncyc, g.pr, g.en, g.hl, g.st, g.cnt,
                     e.pr, e.en, e.hl, e.st, e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-up: reset 2 edges, then pc_reset for 3 cycles
      cyc(1, 0, 0, 0, 0, S_RST, 0);
      cyc(0, 0, 0, 0, 0, S_RST, 0);
      cyc(0, 1, 0, 1, 0, S_RST, 0);
      cyc(0, 0, 0, 0, 0, S_RST, 0);
      cyc(0, 1, 0, 0, 0, S_HALT, 0);
      // Run 11 commits, halt_req in the last
      for (int i = 0; i <= 10; i++)
         cyc(0, 0, (i == 10), 0, 8'(i), S_RUN, 1);
      // All three requests: halt wins
      cyc(0, 1, 1, 1, 0, S_HALT, 0);
      // step + run: step wins
      cyc(0, 1, 0, 1, 0, S_HALT, 0);
      cyc(0, 0, 0, 0, 0, S_STEP, 1);
      // step held 4 cycles: STEP/HALT alternate, +2
      cyc(0, 0, 0, 1, 0, S_HALT, 0);
      cyc(0, 0, 0, 1, 0, S_STEP, 1);
      cyc(0, 0, 0, 1, 0, S_HALT, 0);
      cyc(0, 0, 0, 1, 0, S_STEP, 1);
      cyc(0, 0, 0, 0, 0, S_HALT, 0);
      // Breakpoint at pc 5
      bp_en = 1'b1;
      cyc(0, 1, 0, 0, 0, S_HALT, 0);
`ifdef RUN_CONTROL_BREAKPOINT_EN
      for (int i = 0; i <= 4; i++)
         cyc(0, 0, 0, 0, 8'(i), S_RUN, 1);
      cyc(0, 0, 0, 0, 5, S_RUN, 0);
      cyc(0, 1, 0, 0, 5, S_BRK, 0);
      cyc(0, 0, 0, 0, 5, S_RUN, 1);
      cyc(0, 0, 0, 0, 6, S_RUN, 1);
      cyc(0, 0, 0, 0, 5, S_RUN, 0);
      cyc(0, 0, 0, 1, 5, S_BRK, 0);
      cyc(0, 1, 0, 0, 5, S_STEP, 1);
      cyc(0, 1, 0, 0, 5, S_HALT, 0);
      cyc(0, 0, 0, 0, 5, S_RUN, 0);
      cyc(0, 0, 1, 0, 5, S_BRK, 0);
      cyc(0, 0, 0, 0, 5, S_HALT, 0);
`else
      for (int i = 0; i <= 6; i++)
         cyc(0, 0, 0, 0, 8'(i), S_RUN, 1);
      cyc(0, 0, 0, 0, 5, S_RUN, 1);
      cyc(0, 0, 1, 0, 5, S_RUN, 1);
      cyc(0, 0, 0, 0, 5, S_HALT, 0);
`endif
      bp_en = 1'b0;
      // Reset from HALT, power up, run to count 7, reset mid-RUN
      cyc(1, 0, 0, 0, 0, S_HALT, 0);
      cyc(0, 0, 0, 0, 0, S_RST, 0);
      cyc(0, 0, 0, 0, 0, S_RST, 0);
      cyc(0, 0, 0, 0, 0, S_RST, 0);
      cyc(0, 1, 0, 0, 0, S_HALT, 0);
      for (int i = 0; i <= 6; i++)
         cyc(0, 0, 0, 0, 8'(i), S_RUN, 1);
      cyc(1, 0, 0, 0, 7, S_RUN, 1);
      cyc(0, 0, 0, 0, 0, S_RST, 0);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending exp 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
